// File: rtl/matmul_tile_scheduler.sv
// Tile scheduler for one C = A x B pass on a BLOCK_SIZE x BLOCK_SIZE systolic array.
// Walks output tiles (i,j) and inner steps k, issuing block reads, array pulses and tile writes.
//
// state    | meaning
// IDLE     | waiting for start
// FETCH    | A/B block read strobes issued
// WAIT_RD  | buffer read latency
// LOAD     | systolic array consumes read data
// WAIT_SYS | waiting for the systolic step to finish
// WRITE    | finished tile offered to the result buffer
// NEXT     | advance to the next output tile
// DONE     | completion pulse
module matmul_tile_scheduler #(
   parameter int BLOCK_SIZE      = 2,
   parameter int ROW_A           = 64,
   parameter int INNER_DIMENSION = 64,
   parameter int COL_B           = 64,
   parameter int ADDR_WIDTH      = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  a_rd_en,
   output logic [ADDR_WIDTH-1:0] a_rd_addr,
   output logic                  b_rd_en,
   output logic [ADDR_WIDTH-1:0] b_rd_addr,
   output logic                  sys_start,
   input  logic                  sys_done,
   output logic                  acc_first,
   output logic                  acc_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_addr
);

   localparam int MB = ROW_A / BLOCK_SIZE;
   localparam int KB = INNER_DIMENSION / BLOCK_SIZE;
   localparam int NB = COL_B / BLOCK_SIZE;

   localparam logic [ADDR_WIDTH-1:0] KB_A    = ADDR_WIDTH'(KB);
   localparam logic [ADDR_WIDTH-1:0] NB_A    = ADDR_WIDTH'(NB);
   localparam logic [ADDR_WIDTH-1:0] MB_LAST = ADDR_WIDTH'(MB - 1);
   localparam logic [ADDR_WIDTH-1:0] KB_LAST = ADDR_WIDTH'(KB - 1);
   localparam logic [ADDR_WIDTH-1:0] NB_LAST = ADDR_WIDTH'(NB - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_RD,
      LOAD,
      WAIT_SYS,
      WRITE,
      NEXT,
      DONE
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] i_cnt;
   logic [ADDR_WIDTH-1:0] j_cnt;
   logic [ADDR_WIDTH-1:0] k_cnt;

   // All outputs are registered: each is loaded on the transition into the state that owns it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         i_cnt     <= '0;
         j_cnt     <= '0;
         k_cnt     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         a_rd_en   <= 1'b0;
         a_rd_addr <= '0;
         b_rd_en   <= 1'b0;
         b_rd_addr <= '0;
         sys_start <= 1'b0;
         acc_first <= 1'b0;
         acc_last  <= 1'b0;
         out_valid <= 1'b0;
         out_addr  <= '0;
      end else begin
         a_rd_en   <= 1'b0;
         b_rd_en   <= 1'b0;
         sys_start <= 1'b0;
         acc_first <= 1'b0;
         acc_last  <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= FETCH;
                  busy      <= 1'b1;
                  i_cnt     <= '0;
                  j_cnt     <= '0;
                  k_cnt     <= '0;
                  a_rd_en   <= 1'b1;
                  b_rd_en   <= 1'b1;
                  a_rd_addr <= '0;
                  b_rd_addr <= '0;
               end
            end
            FETCH: state <= WAIT_RD;
            WAIT_RD: begin
               state     <= LOAD;
               sys_start <= 1'b1;
               acc_first <= (k_cnt == '0);
               acc_last  <= (k_cnt == KB_LAST);
            end
            LOAD: state <= WAIT_SYS;
            WAIT_SYS: begin
               if (sys_done) begin
                  if (k_cnt != KB_LAST) begin
                     state     <= FETCH;
                     k_cnt     <= k_cnt + 1'b1;
                     a_rd_en   <= 1'b1;
                     b_rd_en   <= 1'b1;
                     a_rd_addr <= i_cnt * KB_A + k_cnt + 1'b1;
                     b_rd_addr <= j_cnt * KB_A + k_cnt + 1'b1;
                  end else begin
                     state     <= WRITE;
                     k_cnt     <= '0;
                     out_valid <= 1'b1;
                     out_addr  <= i_cnt * NB_A + j_cnt;
                  end
               end
            end
            WRITE: begin
               if (out_ready) begin
                  state     <= NEXT;
                  out_valid <= 1'b0;
               end
            end
            NEXT: begin
               if (j_cnt == NB_LAST) begin
                  j_cnt <= '0;
                  if (i_cnt == MB_LAST) begin
                     state <= DONE;
                     i_cnt <= '0;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state     <= FETCH;
                     i_cnt     <= i_cnt + 1'b1;
                     a_rd_en   <= 1'b1;
                     b_rd_en   <= 1'b1;
                     a_rd_addr <= (i_cnt + 1'b1) * KB_A;
                     b_rd_addr <= '0;
                  end
               end else begin
                  state     <= FETCH;
                  j_cnt     <= j_cnt + 1'b1;
                  a_rd_en   <= 1'b1;
                  b_rd_en   <= 1'b1;
                  a_rd_addr <= i_cnt * KB_A;
                  b_rd_addr <= (j_cnt + 1'b1) * KB_A;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler: scoreboard of expected reads, array steps and tile writes.
module tb_matmul_tile_scheduler;

   typedef struct packed {
      logic [11:0] a;
      logic [11:0] b;
   } rd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic sys_done = 1'b0;
   logic out_ready = 1'b1;
   logic sel = 1'b0;
   logic stray_en = 1'b0;
   int   sys_delay = 1;

   logic start0, start1;
   assign start0 = start & ~sel;
   assign start1 = start & sel;

   logic        d0_busy, d0_done, d0_a_rd_en, d0_b_rd_en, d0_sys_start, d0_acc_first, d0_acc_last, d0_out_valid;
   logic [11:0] d0_a_rd_addr, d0_b_rd_addr, d0_out_addr;
   logic        d1_busy, d1_done, d1_a_rd_en, d1_b_rd_en, d1_sys_start, d1_acc_first, d1_acc_last, d1_out_valid;
   logic [11:0] d1_a_rd_addr, d1_b_rd_addr, d1_out_addr;

   logic        m_busy, m_done, m_a_rd_en, m_b_rd_en, m_sys_start, m_acc_first, m_acc_last, m_out_valid;
   logic [11:0] m_a_rd_addr, m_b_rd_addr, m_out_addr;

   matmul_tile_scheduler #(.BLOCK_SIZE(2), .ROW_A(4), .INNER_DIMENSION(4), .COL_B(4), .ADDR_WIDTH(12)) dut (
      .clk(clk), .rst(rst), .start(start0), .busy(d0_busy), .done(d0_done),
      .a_rd_en(d0_a_rd_en), .a_rd_addr(d0_a_rd_addr), .b_rd_en(d0_b_rd_en), .b_rd_addr(d0_b_rd_addr),
      .sys_start(d0_sys_start), .sys_done(sys_done), .acc_first(d0_acc_first), .acc_last(d0_acc_last),
      .out_valid(d0_out_valid), .out_ready(out_ready), .out_addr(d0_out_addr)
   );

   matmul_tile_scheduler #(.BLOCK_SIZE(2), .ROW_A(4), .INNER_DIMENSION(2), .COL_B(4), .ADDR_WIDTH(12)) dut_k1 (
      .clk(clk), .rst(rst), .start(start1), .busy(d1_busy), .done(d1_done),
      .a_rd_en(d1_a_rd_en), .a_rd_addr(d1_a_rd_addr), .b_rd_en(d1_b_rd_en), .b_rd_addr(d1_b_rd_addr),
      .sys_start(d1_sys_start), .sys_done(sys_done), .acc_first(d1_acc_first), .acc_last(d1_acc_last),
      .out_valid(d1_out_valid), .out_ready(out_ready), .out_addr(d1_out_addr)
   );

   assign m_busy      = sel ? d1_busy      : d0_busy;
   assign m_done      = sel ? d1_done      : d0_done;
   assign m_a_rd_en   = sel ? d1_a_rd_en   : d0_a_rd_en;
   assign m_b_rd_en   = sel ? d1_b_rd_en   : d0_b_rd_en;
   assign m_sys_start = sel ? d1_sys_start : d0_sys_start;
   assign m_acc_first = sel ? d1_acc_first : d0_acc_first;
   assign m_acc_last  = sel ? d1_acc_last  : d0_acc_last;
   assign m_out_valid = sel ? d1_out_valid : d0_out_valid;
   assign m_a_rd_addr = sel ? d1_a_rd_addr : d0_a_rd_addr;
   assign m_b_rd_addr = sel ? d1_b_rd_addr : d0_b_rd_addr;
   assign m_out_addr  = sel ? d1_out_addr  : d0_out_addr;

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   rd_t         exp_rd[$];
   logic [1:0]  exp_sys[$];
   logic [11:0] exp_wr[$];

   int sys_cnt = 0, wr_cnt = 0, done_cnt = 0;
   int base_sys, base_done;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Array-step responder: sys_done answers sys_delay cycles after each sys_start,
   // plus an optional stray sys_done during FETCH.
   int resp_cnt = 0;
   always @(negedge clk) begin
      sys_done = 1'b0;
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) sys_done = 1'b1;
      end
      if (m_sys_start) resp_cnt = sys_delay;
      if (stray_en && m_a_rd_en) sys_done = 1'b1;
   end

   rd_t        mon_rd;
   logic [1:0] mon_sys;
   logic [11:0] mon_wr;
   always @(negedge clk) begin
      if (!rst) begin
         if (m_a_rd_en) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
               mon_rd = exp_rd.pop_front();
               chk("a_rd_addr", m_a_rd_addr, mon_rd.a);
               chk("b_rd_addr", m_b_rd_addr, mon_rd.b);
               chk("b_rd_en", m_b_rd_en, 1);
            end
         end
         if (m_sys_start) begin
            sys_cnt++;
            if (exp_sys.size() == 0) chk("sys_unexpected", 1, 0);
            else begin
               mon_sys = exp_sys.pop_front();
               chk("acc_first_last", {m_acc_first, m_acc_last}, mon_sys);
            end
         end else if (m_acc_first || m_acc_last) begin
            chk("acc_without_sys_start", {m_acc_first, m_acc_last}, 0);
         end
         if (m_out_valid && out_ready) begin
            wr_cnt++;
            if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
               mon_wr = exp_wr.pop_front();
               chk("out_addr", m_out_addr, mon_wr);
            end
         end
         if (m_done) begin
            done_cnt++;
            chk("busy_at_done", m_busy, 0);
         end
      end
   end

   task automatic push_expected(input int mb, input int kb, input int nb);
      rd_t r;
      for (int i = 0; i < mb; i++)
         for (int j = 0; j < nb; j++) begin
            for (int k = 0; k < kb; k++) begin
               r.a = 12'(i * kb + k);
               r.b = 12'(j * kb + k);
               exp_rd.push_back(r);
               exp_sys.push_back({k == 0, k == kb - 1});
            end
            exp_wr.push_back(12'(i * nb + j));
         end
   endtask

   task automatic begin_test(input int mb, input int kb, input int nb);
      exp_rd.delete();
      exp_sys.delete();
      exp_wr.delete();
      base_sys  = sys_cnt;
      base_done = done_cnt;
      push_expected(mb, kb, nb);
   endtask

   task automatic start_pulse();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("busy_after_start", m_busy, 1);
   endtask

   task automatic run_full(input string tag, input int budget, input int n_sys);
      int c;
      c = 0;
      while (c < budget && done_cnt == base_done) begin
         @(negedge clk); #1;
         c++;
      end
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk({tag, "_done_count"}, done_cnt - base_done, 1);
      chk({tag, "_sys_count"}, sys_cnt - base_sys, n_sys);
      chk({tag, "_busy_end"}, m_busy, 0);
      chk({tag, "_rd_left"}, exp_rd.size(), 0);
      chk({tag, "_sys_left"}, exp_sys.size(), 0);
      chk({tag, "_wr_left"}, exp_wr.size(), 0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ctrl"}, {m_busy, m_done, m_a_rd_en, m_b_rd_en, m_sys_start, m_acc_first, m_acc_last, m_out_valid}, 0);
      chk({tag, "_addr"}, {m_a_rd_addr, m_b_rd_addr, m_out_addr}, 0);
   endtask

   initial begin
      int c;
      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset_d0");
      chk("reset_d1", {d1_busy, d1_done, d1_a_rd_en, d1_sys_start, d1_out_valid, d1_out_addr}, 0);
      rst = 1'b0;

      // 1: nominal run
      begin_test(2, 2, 2);
      start_pulse();
      run_full("t1", 200, 8);

      // 2: result buffer stalls on the first tile
      begin_test(2, 2, 2);
      out_ready = 1'b0;
      start_pulse();
      c = 0;
      while (c < 50 && !m_out_valid) begin
         @(negedge clk);
         c++;
      end
      chk("t2_write_reached", m_out_valid, 1);
      for (int n = 0; n < 5; n++) begin
         chk("t2_stall_valid", m_out_valid, 1);
         chk("t2_stall_addr", m_out_addr, 0);
         chk("t2_stall_no_read", m_a_rd_en, 0);
         @(negedge clk);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      run_full("t2", 200, 8);

      // 3: start hammered while busy, stray sys_done in FETCH, start on the done cycle
      begin_test(2, 2, 2);
      stray_en = 1'b1;
      start_pulse();
      c = 0;
      while (c < 200) begin
         @(posedge clk); #1;
         if (m_done) break;
         start = (c % 3 == 1);
         c++;
      end
      chk("t3_done_seen", m_done, 1);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      chk("t3_start_on_done_ignored", m_busy, 0);
      stray_en = 1'b0;
      run_full("t3", 5, 8);

      // 4: reset during WAIT_SYS of the second tile, then a clean replay
      begin_test(2, 2, 2);
      start_pulse();
      c = 0;
      while (c < 100 && !(m_sys_start && wr_cnt > 0 && exp_wr.size() == 3)) begin
         @(negedge clk);
         c++;
      end
      chk("t4_tile2_reached", m_sys_start, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      chk_idle("t4_after_rst");
      rst = 1'b0;
      begin_test(2, 2, 2);
      start_pulse();
      run_full("t4", 200, 8);

      // 6: slow systolic array
      sys_delay = 10;
      begin_test(2, 2, 2);
      start_pulse();
      run_full("t6", 400, 8);
      sys_delay = 1;

      // 5: single inner step per tile
      sel = 1'b1;
      @(posedge clk); #1;
      begin_test(2, 1, 2);
      start_pulse();
      run_full("t5", 200, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
